// File: rtl/xor_hash_seq_if.sv
// Handshake bundle for the multi-cycle cache-line XOR hash.
// The producer/consumer side is the master; the hash block is the slave.
interface xor_hash_seq_if #(
    parameter int LARGURA_LINHA = 512,
    parameter int LARGURA_HASH  = 8
);
    logic                     entrada_valida;
    logic                     entrada_pronta;
    logic [LARGURA_LINHA-1:0] linha_cache;
    logic                     modo;
    logic                     saida_valida;
    logic                     saida_pronta;
    logic [LARGURA_HASH-1:0]  saida;

    modport master (
        output entrada_valida,
        output linha_cache,
        output modo,
        output saida_pronta,
        input  entrada_pronta,
        input  saida_valida,
        input  saida
    );

    modport slave (
        input  entrada_valida,
        input  linha_cache,
        input  modo,
        input  saida_pronta,
        output entrada_pronta,
        output saida_valida,
        output saida
    );
endinterface

// File: rtl/xor_hash_seq.sv
// Multi-cycle XOR / rotate-XOR fold of a cache line into a set index.
// Folds BLOCOS_POR_CICLO blocks per clock, most significant block first.
module xor_hash_seq #(
    parameter int LARGURA_LINHA    = 512,
    parameter int LARGURA_HASH     = 8,
    parameter int BLOCOS_POR_CICLO = 8
) (
    input  logic          clk,
    input  logic          rst,
    xor_hash_seq_if.slave bus
);
    localparam int H     = LARGURA_HASH;
    localparam int B     = BLOCOS_POR_CICLO;
    localparam int L     = LARGURA_LINHA;
    localparam int NB    = L / H;
    localparam int NC    = NB / B;
    localparam int CW    = (NC > 1) ? $clog2(NC) : 1;
    localparam int PASSO = B * H;

    if ((L % (H * B)) != 0) begin : g_erro_divisao
        $error("LARGURA_LINHA must be divisible by LARGURA_HASH*BLOCOS_POR_CICLO");
    end
    if (H < 2) begin : g_erro_hash
        $error("LARGURA_HASH must be at least 2");
    end

    typedef enum logic [1:0] {
        OCIOSO,
        CALC,
        PRONTO
    } estado_t;

    estado_t        estado;
    estado_t        estado_nxt;
    logic [L-1:0]   linha_r;
    logic           modo_r;
    logic [H-1:0]   acc;
    logic [H-1:0]   acc_nxt;
    logic [H-1:0]   blk;
    logic [CW-1:0]  cnt;
    logic [H-1:0]   saida_r;
    logic           ultimo;

    assign ultimo = (cnt == CW'(NC - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_nxt;
        end
    end

    // Next-state decode: accept, count through the line, wait for consumer.
    always_comb begin
        estado_nxt = estado;
        unique case (estado)
            OCIOSO: if (bus.entrada_valida) estado_nxt = CALC;
            CALC:   if (ultimo) estado_nxt = PRONTO;
            PRONTO: if (bus.saida_pronta) estado_nxt = OCIOSO;
            default: estado_nxt = OCIOSO;
        endcase
    end

    // Handshake outputs follow the state directly.
    always_comb begin
        bus.entrada_pronta = 1'b0;
        bus.saida_valida   = 1'b0;
        unique case (estado)
            OCIOSO:  bus.entrada_pronta = 1'b1;
            PRONTO:  bus.saida_valida   = 1'b1;
            default: ;
        endcase
    end

    assign bus.saida = saida_r;

    // Fold the B blocks at the top of the shifted line register into acc.
    always_comb begin
        acc_nxt = acc;
        blk     = '0;
        for (int j = 0; j < B; j++) begin
            blk = linha_r[L-1-j*H -: H];
            if (modo_r) begin
                acc_nxt = {acc_nxt[H-2:0], acc_nxt[H-1]} ^ blk;
            end else begin
                acc_nxt = acc_nxt ^ blk;
            end
        end
    end

    // Datapath: latch the line on accept, shift consumed blocks out, publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            linha_r <= '0;
            modo_r  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            saida_r <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (bus.entrada_valida) begin
                        linha_r <= bus.linha_cache;
                        modo_r  <= bus.modo;
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    acc     <= acc_nxt;
                    linha_r <= linha_r << PASSO;
                    cnt     <= cnt + CW'(1);
                    if (ultimo) saida_r <= acc_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_hash_seq.sv
// Bench for xor_hash_seq at the default and a 256/16/4 configuration.
// Expected hashes are queued at accept and popped when saida_valida rises.
module tb_xor_hash_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor_hash_seq_if #(.LARGURA_LINHA(512), .LARGURA_HASH(8))  bus_a ();
    xor_hash_seq_if #(.LARGURA_LINHA(256), .LARGURA_HASH(16)) bus_b ();

    xor_hash_seq #(
        .LARGURA_LINHA(512), .LARGURA_HASH(8), .BLOCOS_POR_CICLO(8)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    xor_hash_seq #(
        .LARGURA_LINHA(256), .LARGURA_HASH(16), .BLOCOS_POR_CICLO(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        logic [511:0] linha;
        logic         modo;
        logic [7:0]   esperado;
    } vec_a_t;

    int total = 0;
    int bad   = 0;

    logic [7:0]  q_a [$];
    logic [15:0] q_b [$];

    task automatic chk(input bit ok, input string nome,
                       input logic [63:0] got, input logic [63:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nome, got, want);
        end
    endtask

    function automatic logic [7:0] ref_a(input logic [511:0] l, input logic m);
        logic [7:0] a;
        logic [7:0] b;
        a = '0;
        for (int k = 0; k < 64; k++) begin
            b = l[511-k*8 -: 8];
            a = m ? ({a[6:0], a[7]} ^ b) : (a ^ b);
        end
        return a;
    endfunction

    function automatic logic [15:0] ref_b(input logic [255:0] l, input logic m);
        logic [15:0] a;
        logic [15:0] b;
        a = '0;
        for (int k = 0; k < 16; k++) begin
            b = l[255-k*16 -: 16];
            a = m ? ({a[14:0], a[15]} ^ b) : (a ^ b);
        end
        return a;
    endfunction

    function automatic logic [511:0] rand_a();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [255:0] rand_b();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic wait_idle_a(input string nome);
        int e = 0;
        while (!bus_a.entrada_pronta && e < 40) begin
            @(negedge clk);
            e++;
        end
        if (e >= 40) chk(1'b0, {nome, " idle timeout"}, 64'(e), 64'(40));
    endtask

    task automatic wait_idle_b(input string nome);
        int e = 0;
        while (!bus_b.entrada_pronta && e < 40) begin
            @(negedge clk);
            e++;
        end
        if (e >= 40) chk(1'b0, {nome, " idle timeout"}, 64'(e), 64'(40));
    endtask

    task automatic run_a(input logic [511:0] l, input logic m,
                         input logic [7:0] want, input string nome);
        int e;
        logic [7:0] exp_v;
        wait_idle_a(nome);
        bus_a.linha_cache    = l;
        bus_a.modo           = m;
        bus_a.entrada_valida = 1'b1;
        q_a.push_back(want);
        @(negedge clk);
        bus_a.entrada_valida = 1'b0;
        bus_a.linha_cache    = rand_a();
        bus_a.modo           = ~m;
        e = 0;
        while (!bus_a.saida_valida && e < 40) begin
            @(negedge clk);
            e++;
        end
        chk(e == 8, {nome, " latency"}, 64'(e), 64'(8));
        if (bus_a.saida_valida && q_a.size() > 0) begin
            exp_v = q_a.pop_front();
            chk(bus_a.saida == exp_v, nome, 64'(bus_a.saida), 64'(exp_v));
        end
        bus_a.saida_pronta = 1'b1;
        @(negedge clk);
        bus_a.saida_pronta = 1'b0;
        chk(!bus_a.saida_valida && bus_a.entrada_pronta, {nome, " release"},
            64'({bus_a.saida_valida, bus_a.entrada_pronta}), 64'(2'b01));
    endtask

    task automatic run_b(input logic [255:0] l, input logic m,
                         input logic [15:0] want, input string nome);
        int e;
        logic [15:0] exp_v;
        wait_idle_b(nome);
        bus_b.linha_cache    = l;
        bus_b.modo           = m;
        bus_b.entrada_valida = 1'b1;
        q_b.push_back(want);
        @(negedge clk);
        bus_b.entrada_valida = 1'b0;
        bus_b.linha_cache    = rand_b();
        bus_b.modo           = ~m;
        e = 0;
        while (!bus_b.saida_valida && e < 40) begin
            @(negedge clk);
            e++;
        end
        if (e != 4) chk(1'b0, {nome, " latency"}, 64'(e), 64'(4));
        else        chk(1'b1, {nome, " latency"}, 64'(e), 64'(4));
        if (bus_b.saida_valida && q_b.size() > 0) begin
            exp_v = q_b.pop_front();
            chk(bus_b.saida == exp_v, nome, 64'(bus_b.saida), 64'(exp_v));
        end
        bus_b.saida_pronta = 1'b1;
        @(negedge clk);
        bus_b.saida_pronta = 1'b0;
    endtask

    initial begin
        vec_a_t       tab [7];
        logic [511:0] l;
        logic [255:0] lb;
        logic [7:0]   held;
        bit           st_v, st_s, st_p;
        int           e;

        rst = 1'b1;
        bus_a.entrada_valida = 1'b0;
        bus_a.linha_cache    = '0;
        bus_a.modo           = 1'b0;
        bus_a.saida_pronta   = 1'b0;
        bus_b.entrada_valida = 1'b0;
        bus_b.linha_cache    = '0;
        bus_b.modo           = 1'b0;
        bus_b.saida_pronta   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk(bus_a.entrada_pronta == 1'b1, "rst a pronta", 64'(bus_a.entrada_pronta), 64'(1));
        chk(bus_a.saida_valida == 1'b0, "rst a valida", 64'(bus_a.saida_valida), 64'(0));
        chk(bus_a.saida == 8'h00, "rst a saida", 64'(bus_a.saida), 64'(0));
        chk(bus_b.entrada_pronta == 1'b1, "rst b pronta", 64'(bus_b.entrada_pronta), 64'(1));
        chk(bus_b.saida_valida == 1'b0, "rst b valida", 64'(bus_b.saida_valida), 64'(0));

        tab[0] = '{512'(0), 1'b0, 8'h00};
        l = '0;
        l[511 -: 8] = 8'hA5;
        tab[1] = '{l, 1'b0, 8'hA5};
        tab[2] = '{l, 1'b1, 8'hD2};
        tab[3] = '{{64{8'hFF}}, 1'b0, 8'h00};
        l = '0;
        for (int k = 0; k < 64; k++) l[511-k*8 -: 8] = 8'(k);
        tab[4] = '{l, 1'b0, 8'h00};
        l = '0;
        l[511 -: 8] = 8'h01;
        tab[5] = '{l, 1'b1, 8'h80};
        l = '0;
        l[7:0] = 8'h01;
        tab[6] = '{l, 1'b1, 8'h01};

        for (int i = 0; i < 7; i++) begin
            run_a(tab[i].linha, tab[i].modo, tab[i].esperado, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            l = rand_a();
            run_a(l, 1'(i), ref_a(l, 1'(i)), $sformatf("rand_a%0d", i));
        end

        // Backpressure: hold the result for 20 cycles with a stray request.
        wait_idle_a("bp");
        l = '0;
        l[511 -: 8] = 8'h3C;
        bus_a.linha_cache    = l;
        bus_a.modo           = 1'b0;
        bus_a.entrada_valida = 1'b1;
        q_a.push_back(8'h3C);
        @(negedge clk);
        bus_a.entrada_valida = 1'b0;
        e = 0;
        while (!bus_a.saida_valida && e < 40) begin
            @(negedge clk);
            e++;
        end
        chk(e == 8, "bp latency", 64'(e), 64'(8));
        held = q_a.pop_front();
        chk(bus_a.saida == held, "bp result", 64'(bus_a.saida), 64'(held));
        st_v = 1'b1;
        st_s = 1'b1;
        st_p = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i >= 5 && i < 10) begin
                bus_a.entrada_valida = 1'b1;
                bus_a.linha_cache    = rand_a();
            end else begin
                bus_a.entrada_valida = 1'b0;
            end
            @(negedge clk);
            st_v &= bus_a.saida_valida;
            st_s &= (bus_a.saida == held);
            st_p &= !bus_a.entrada_pronta;
        end
        bus_a.entrada_valida = 1'b0;
        chk(st_v, "bp valida held", 64'(st_v), 64'(1));
        chk(st_s, "bp saida stable", 64'(bus_a.saida), 64'(held));
        chk(st_p, "bp pronta low", 64'(st_p), 64'(1));
        bus_a.saida_pronta = 1'b1;
        @(negedge clk);
        bus_a.saida_pronta = 1'b0;
        chk(!bus_a.saida_valida && bus_a.entrada_pronta, "bp release",
            64'({bus_a.saida_valida, bus_a.entrada_pronta}), 64'(2'b01));
        repeat (12) @(negedge clk);
        chk(!bus_a.saida_valida && bus_a.entrada_pronta, "bp not queued",
            64'({bus_a.saida_valida, bus_a.entrada_pronta}), 64'(2'b01));

        // Reset sampled on the fourth CALC edge aborts the job.
        wait_idle_a("rst");
        l = rand_a();
        bus_a.linha_cache    = l;
        bus_a.modo           = 1'b1;
        bus_a.entrada_valida = 1'b1;
        q_a.push_back(ref_a(l, 1'b1));
        @(negedge clk);
        bus_a.entrada_valida = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        chk(bus_a.saida_valida == 1'b0, "rst mid valida", 64'(bus_a.saida_valida), 64'(0));
        chk(bus_a.entrada_pronta == 1'b1, "rst mid pronta", 64'(bus_a.entrada_pronta), 64'(1));
        chk(bus_a.saida == 8'h00, "rst mid saida", 64'(bus_a.saida), 64'(0));
        st_v = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            st_v |= bus_a.saida_valida;
        end
        chk(!st_v, "rst no partial", 64'(st_v), 64'(0));
        l = rand_a();
        run_a(l, 1'b0, ref_a(l, 1'b0), "after rst");

        lb = '0;
        lb[255 -: 16] = 16'h0001;
        run_b(lb, 1'b1, 16'h8000, "b blk0 rot");
        lb = '0;
        lb[15:0] = 16'h0001;
        run_b(lb, 1'b1, 16'h0001, "b blk15 rot");
        for (int i = 0; i < 1000; i++) begin
            lb = rand_b();
            run_b(lb, 1'(i), ref_b(lb, 1'(i)), $sformatf("rand_b%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
